// File: rtl/uart_alu_packet_parser.sv
// Byte-stream packet parser: decodes {opcode, rsvd, len_lo, len_hi} headers and
// hands LEN little-endian operands to the ALU with first/last tags.
module uart_alu_packet_parser #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter logic [7:0]  OP_ADD = 8'h10,
  parameter logic [7:0]  OP_MUL = 8'h11,
  parameter logic [7:0]  OP_DIV = 8'h12
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [7:0]        opcode_o,
  output logic [DATA_W-1:0] operand_o,
  output logic              operand_valid_o,
  input  logic              operand_ready_i,
  output logic              operand_first_o,
  output logic              operand_last_o,
  output logic              error_o,
  output logic              busy_o
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned BI_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CNT_W = LEN_W + BI_W;
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(NB - 1);

  typedef enum logic [2:0] {
    S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_DATA, S_DISCARD
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [BI_W-1:0]   bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              rx_ready;
  logic              rx_fire;
  logic              drain;
  logic              op_ok;
  logic [LEN_W-1:0]  len_new;
  logic [DATA_W-1:0] asm_wr;

  always_comb begin
    drain = out_valid_q & operand_ready_i;
    // Output register is "free" if empty or being consumed this very cycle.
    unique case (state_q)
      S_OPCODE: rx_ready = !out_valid_q || operand_ready_i;
      S_DATA:   rx_ready = !(bcnt_q == LAST_BYTE && out_valid_q && !operand_ready_i);
      default:  rx_ready = 1'b1;
    endcase
    rx_fire = rx_valid_i & rx_ready;
    op_ok   = (opcode_q == OP_ADD) || (opcode_q == OP_MUL) || (opcode_q == OP_DIV);
    len_new = LEN_W'({rx_data_i, len_q[7:0]});
    asm_wr  = asm_q;
    asm_wr[{bcnt_q, 3'b000} +: 8] = rx_data_i;
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    len_d       = len_q;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    dcnt_d      = dcnt_q;
    asm_d       = asm_q;
    out_d       = out_q;
    out_valid_d = drain ? 1'b0 : out_valid_q;
    first_d     = first_q;
    last_d      = last_q;
    err_d       = 1'b0;
    busy_d      = (drain && last_q) ? 1'b0 : busy_q;

    if (rx_fire) begin
      unique case (state_q)
        S_OPCODE: begin
          opcode_d = rx_data_i;
          busy_d   = 1'b1;
          state_d  = S_RSVD;
        end
        S_RSVD: state_d = S_LEN_LO;
        S_LEN_LO: begin
          len_d   = {len_q[LEN_W-1:8], rx_data_i};
          state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d  = len_new;
          idx_d  = '0;
          bcnt_d = '0;
          if (len_new == '0) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_OPCODE;
          end else if (!op_ok) begin
            err_d   = 1'b1;
            dcnt_d  = CNT_W'(len_new) * CNT_W'(NB);
            state_d = S_DISCARD;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          asm_d  = asm_wr;
          bcnt_d = bcnt_q + BI_W'(1);
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d      = '0;
            out_d       = asm_wr;
            out_valid_d = 1'b1;
            first_d     = (idx_q == '0);
            last_d      = (idx_q == len_q - LEN_W'(1));
            idx_d       = idx_q + LEN_W'(1);
            if (idx_q == len_q - LEN_W'(1)) state_d = S_OPCODE;
          end
        end
        S_DISCARD: begin
          dcnt_d = dcnt_q - CNT_W'(1);
          if (dcnt_q == CNT_W'(1)) begin
            busy_d  = 1'b0;
            state_d = S_OPCODE;
          end
        end
        default: state_d = S_OPCODE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_OPCODE;
      opcode_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      dcnt_q      <= '0;
      asm_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      dcnt_q      <= dcnt_d;
      asm_q       <= asm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_ready_o      = rx_ready;
  assign opcode_o        = opcode_q;
  assign operand_o       = out_q;
  assign operand_valid_o = out_valid_q;
  assign operand_first_o = out_valid_q & first_q;
  assign operand_last_o  = out_valid_q & last_q;
  assign error_o         = err_q;
  assign busy_o          = busy_q;

endmodule
